// File: rtl/det_event_monitor.sv
// det_event_monitor: counts pattern-detector pulses, measures inter-detection gaps,
// and raises a software-acknowledged alarm on bursts of THRESH detections within WIN cycles.
module det_event_monitor #(
  parameter int CNT_W  = 8,
  parameter int WIN    = 16,
  parameter int THRESH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w,
  input  logic             clr,
  input  logic             ack,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] last_gap,
  output logic             gap_vld,
  output logic             busy,
  output logic             alarm
);
  localparam int HW = $clog2(THRESH + 1);
  localparam int WW = $clog2(WIN);
  typedef enum logic [1:0] {IDLE, ARMED, ALARM} state_t;
  state_t           r_state, w_state_n;
  logic [HW-1:0]    r_hit, w_hit_n;
  logic [WW-1:0]    r_win, w_win_n;
  logic [CNT_W-1:0] r_total, r_gap, r_run;
  logic             r_gap_vld, r_seen;
  logic             w_last, w_trip;
  assign w_last = r_win == WW'(WIN - 1);
  assign w_trip = w && (r_hit + HW'(1) == HW'(THRESH));
  // a detection on the expiring edge or on the acknowledging edge opens a fresh window
  always_comb begin
    w_state_n = r_state;
    w_hit_n   = r_hit;
    w_win_n   = r_win;
    case (r_state)
      IDLE: if (w) begin
        w_state_n = ARMED;
        w_hit_n   = HW'(1);
        w_win_n   = '0;
      end
      ARMED: if (w_trip) w_state_n = ALARM;
      else if (w_last) begin
        w_state_n = w ? ARMED : IDLE;
        w_hit_n   = HW'(w);
        w_win_n   = '0;
      end else begin
        w_win_n = r_win + WW'(1);
        w_hit_n = r_hit + HW'(w);
      end
      ALARM: if (ack) begin
        w_state_n = w ? ARMED : IDLE;
        w_hit_n   = HW'(w);
        w_win_n   = '0;
      end
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_hit     <= '0;
      r_win     <= '0;
      r_total   <= '0;
      r_gap     <= '0;
      r_run     <= '0;
      r_gap_vld <= 1'b0;
      r_seen    <= 1'b0;
    end else if (clr) begin
      r_state   <= IDLE;
      r_hit     <= '0;
      r_win     <= '0;
      r_total   <= '0;
      r_gap     <= '0;
      r_run     <= '0;
      r_gap_vld <= 1'b0;
      r_seen    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_hit   <= w_hit_n;
      r_win   <= w_win_n;
      r_run   <= w ? '0 : r_run + CNT_W'(~&r_run);
      if (w) begin
        r_total <= r_total + CNT_W'(~&r_total);
        r_seen  <= 1'b1;
        if (r_seen) begin
          r_gap     <= r_run + CNT_W'(~&r_run);
          r_gap_vld <= 1'b1;
        end
      end
    end
  end
  assign total_cnt = r_total;
  assign last_gap  = r_gap;
  assign gap_vld   = r_gap_vld;
  assign busy      = r_state == ARMED;
  assign alarm     = r_state == ALARM;
endmodule

// File: doc/det_event_monitor.md
Name: det_event_monitor

Overview:
- Downstream consumer of the serial pattern detector's Mealy match output `w`: one pulse per detected 10010 occurrence, overlapping allowed, minimum 3 cycles between pulses in normal operation.
- Keeps a saturating count of detections and measures the gap between consecutive detections.
- Runs a burst-alarm FSM that raises `alarm` when THRESH detections occur inside a WIN-cycle window; `alarm` holds until software acknowledges it.
- `w` is sampled at the rising edge of `clk`. The block adds no combinational path from `w` to any output.

Parameters:
- CNT_W, 8, width of `total_cnt`, `last_gap` and the internal gap runner.
- WIN, 16, burst window length in cycles after the opening detection. Legal range is 2 or more.
- THRESH, 3, number of detections (including the opening one) that trigger the alarm. Legal range is 2..WIN+1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- w  in  1  detection pulse from the pattern detector.
- clr  in  1  synchronous clear of counters and FSM.
- ack  in  1  alarm acknowledge, sampled on the clock edge.
- total_cnt  out  CNT_W  detections seen, saturating at 2^CNT_W-1.
- last_gap  out  CNT_W  cycles between the two most recent detections, saturating.
- gap_vld  out  1  `last_gap` holds a real measurement (at least 2 detections since reset/clr).
- busy  out  1  FSM is in ARMED.
- alarm  out  1  FSM is in ALARM.

Behaviour:
- Reset (async, rst=1): state IDLE; `total_cnt`=0, `last_gap`=0, `gap_vld`=0, `busy`=0, `alarm`=0; internal hit, window and gap counters cleared.
- `clr`=1 at an edge: same effect as reset, synchronous. It has priority over `w` and `ack`; a `w` pulse in that cycle is discarded.
- All outputs are registered. Effects of `w` at edge k are visible after edge k.
- total_cnt:
  - On each sampled w=1, increment by 1.
  - Hold at all-ones once reached; no wrap.
- Gap measurement:
  - A gap runner increments every cycle, saturating at all-ones.
  - On w=1 the runner resets to 0. If a previous detection exists, `last_gap` <= min(runner+1, 2^CNT_W-1) and `gap_vld` <= 1.
  - Detections at edges k and k+3 give last_gap=3.
- FSM states: IDLE, ARMED, ALARM. The window counter `win` and hit counter `hit` are sized to hold WIN-1 and THRESH.
- IDLE:
  - w=1: go to ARMED with hit=1, win=0.
  - Otherwise stay in IDLE.
- ARMED, evaluated each edge in this priority order:
  1. w=1 and hit+1==THRESH: go to ALARM.
  2. Else win==WIN-1 (window expired): if w=1, stay ARMED with hit=1, win=0 (new window); else go to IDLE.
  3. Else win<=win+1 and hit<=hit+w.
  - Net effect: detections at edges k+1..k+WIN after the opening detection at edge k count toward THRESH. A detection at k+WIN still counts.
- ALARM:
  - Hold until ack=1. Detections continue to update `total_cnt` and the gap logic but do not affect the FSM.
  - ack=1 with w=0: go to IDLE.
  - ack=1 with w=1: go to ARMED with hit=1, win=0; the same-cycle detection opens a new window.
- `ack` outside ALARM is ignored.
- Reset or clr in the middle of ARMED or ALARM: immediate return to IDLE with all counters zeroed. `alarm` drops with no acknowledge required.
- An X/glitch on combinational `w` between edges is irrelevant; only the edge-sampled value matters.

Test Plan:
- Reset check: assert rst mid-run with counters nonzero -> all outputs 0 immediately, before the next clock edge; after release with w=0 for 20 cycles -> outputs stay 0, state IDLE.
- Count/gap: w pulses at edges 0, 3, 10 -> total_cnt=3, last_gap=7, gap_vld=1 after edge 10; gap_vld=0 after edge 0 only.
- Burst alarm (WIN=16, THRESH=3): w at edges 0, 5, 16 -> busy=1 after edge 0, alarm=1 after edge 16; alarm holds 10 cycles with ack=0; ack at edge 30 -> alarm=0, busy=0.
- Window expiry: w at edges 0, 5, 17 -> busy drops after edge 16, no alarm; busy=1 again after edge 17 with a fresh window; then w at 20 and 25 -> alarm after edge 25.
- Simultaneous events: in ALARM, ack=1 and w=1 at the same edge -> alarm=0, busy=1, total_cnt increments. clr=1 with w=1 -> total_cnt=0, IDLE.
- Saturation (CNT_W=4): 20 detections spaced 3 cycles apart -> total_cnt=15 holds. Then idle 30 cycles and detect -> last_gap=15.
